// File: rtl/day_counter.sv
// Day counter for the DE10-Lite board.
// A prescaler divides ADC_CLK_10 down to a one-cycle day tick. A two-digit
// BCD counter steps 01..99 and wraps back to 01 on each tick. The count is
// shown on HEX5 (tens) and HEX4 (ones), and LED0 blinks at the day rate.
module day_counter #(
    parameter int DIV   = 10_000_000,  // clocks per day tick, even and >= 2
    parameter int CNT_W = 24           // prescaler width, 2**CNT_W >= DIV
) (
    input  logic       ADC_CLK_10,
    input  logic       reset,          // asynchronous, active-low
    output logic       LED0,
    output logic [7:0] HEX0,
    output logic [7:0] HEX1,
    output logic [7:0] HEX2,
    output logic [7:0] HEX3,
    output logic [7:0] HEX4,
    output logic [7:0] HEX5
);

    // Prescaler terminal count and the point where LED0 turns on.
    localparam logic [CNT_W-1:0] LAST = CNT_W'(DIV - 1);
    localparam logic [CNT_W-1:0] HALF = CNT_W'(DIV / 2);

    // Active-low 7-segment codes. Bit 7 is the decimal point and stays off.
    localparam logic [7:0] SEG_BLANK = 8'hFF;

    logic [CNT_W-1:0] prescaler;
    logic [CNT_W-1:0] prescaler_next;
    logic             tick;
    logic [3:0]       tens;
    logic [3:0]       ones;

    // Convert one BCD digit to its segment pattern.
    function automatic logic [7:0] seg_decode(input logic [3:0] digit);
        logic [7:0] seg;
        // NOTE: the default arm gives every path a value, so no latch is
        // inferred; it also blanks the display for a non-BCD digit.
        case (digit)
            4'd0:    seg = 8'hC0;
            4'd1:    seg = 8'hF9;
            4'd2:    seg = 8'hA4;
            4'd3:    seg = 8'hB0;
            4'd4:    seg = 8'h99;
            4'd5:    seg = 8'h92;
            4'd6:    seg = 8'h82;
            4'd7:    seg = 8'hF8;
            4'd8:    seg = 8'h80;
            4'd9:    seg = 8'h90;
            default: seg = SEG_BLANK;
        endcase
        return seg;
    endfunction

    // Tick on the last prescaler count; the prescaler wraps to 0 there.
    always_comb begin
        tick           = (prescaler == LAST);
        prescaler_next = tick ? '0 : prescaler + CNT_W'(1);
    end

    // Prescaler and LED0. LED0 is driven from the next prescaler value so
    // the register holds (prescaler >= DIV/2) for the current count and falls
    // on the same edge that advances the day.
    always_ff @(posedge ADC_CLK_10 or negedge reset) begin
        if (!reset) begin
            prescaler <= '0;
            LED0      <= 1'b0;
        end else begin
            // NOTE: non-blocking assignments keep every register sampling the
            // pre-edge state, whatever order the statements appear in.
            prescaler <= prescaler_next;
            LED0      <= (prescaler_next >= HALF);
        end
    end

    // Two-digit BCD day count: 01..99, then back to 01. Never shows 00.
    always_ff @(posedge ADC_CLK_10 or negedge reset) begin
        if (!reset) begin
            tens <= 4'd0;
            ones <= 4'd1;
        end else if (tick) begin
            if (tens == 4'd9 && ones == 4'd9) begin
                tens <= 4'd0;
                ones <= 4'd1;
            end else if (ones == 4'd9) begin
                tens <= tens + 4'd1;
                ones <= 4'd0;
            end else begin
                ones <= ones + 4'd1;
            end
        end
    end

    // Display outputs: combinational decode of the registered digits, so
    // they follow the digits with no extra latency, including during reset.
    always_comb begin
        HEX0 = SEG_BLANK;
        HEX1 = SEG_BLANK;
        HEX2 = SEG_BLANK;
        HEX3 = SEG_BLANK;
        HEX4 = seg_decode(ones);
        HEX5 = seg_decode(tens);
    end

endmodule

// File: tb/tb_day_counter.sv
// Self-checking bench for day_counter. A short-period instance (DIV=4)
// covers the counting sequence, carries, wrap and asynchronous reset; a
// second instance (DIV=10) covers LED0 duty and the single advance per
// period. Outputs are sampled on the falling clock edge.
module tb_day_counter;

    localparam logic [7:0] S0 = 8'hC0, S1 = 8'hF9, S2 = 8'hA4, S3 = 8'hB0;
    localparam logic [7:0] S7 = 8'hF8, S9 = 8'h90, BLANK = 8'hFF;

    logic       clk;
    logic       rst_n;
    logic       led_a, led_b;
    logic [7:0] a_hex0, a_hex1, a_hex2, a_hex3, a_hex4, a_hex5;
    logic [7:0] b_hex0, b_hex1, b_hex2, b_hex3, b_hex4, b_hex5;

    int vectors = 0;
    int miscompares = 0;

    day_counter #(.DIV(4), .CNT_W(2)) dut_a (
        .ADC_CLK_10 (clk),
        .reset      (rst_n),
        .LED0       (led_a),
        .HEX0       (a_hex0),
        .HEX1       (a_hex1),
        .HEX2       (a_hex2),
        .HEX3       (a_hex3),
        .HEX4       (a_hex4),
        .HEX5       (a_hex5)
    );

    day_counter #(.DIV(10), .CNT_W(4)) dut_b (
        .ADC_CLK_10 (clk),
        .reset      (rst_n),
        .LED0       (led_b),
        .HEX0       (b_hex0),
        .HEX1       (b_hex1),
        .HEX2       (b_hex2),
        .HEX3       (b_hex3),
        .HEX4       (b_hex4),
        .HEX5       (b_hex5)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        int         clocks;   // rising edges to apply before sampling
        logic       led;
        logic [7:0] hex5;
        logic [7:0] hex4;
    } vec_t;

    vec_t table_a[9];

    task automatic check(input string name, input logic [7:0] act, input logic [7:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %02h, expected %02h at %0t", name, act, exp, $time);
        end
    endtask

    // Check all outputs of instance A against an expected day display.
    task automatic check_a(input string name, input logic led, input logic [7:0] h5, input logic [7:0] h4);
        check({name, " LED0"}, {7'd0, led_a}, {7'd0, led});
        check({name, " HEX5"}, a_hex5, h5);
        check({name, " HEX4"}, a_hex4, h4);
        check({name, " HEX0-3"}, a_hex0 & a_hex1 & a_hex2 & a_hex3, BLANK);
        check({name, " HEX0|3"}, a_hex0 | a_hex1 | a_hex2 | a_hex3, BLANK);
    endtask

    // Apply n rising edges, then sample at the following falling edge.
    task automatic run(input int n);
        repeat (n) @(posedge clk);
        @(negedge clk);
    endtask

    // Reset at a falling edge; release at the next falling edge so the
    // first counting edge follows half a period later.
    task automatic do_reset();
        @(negedge clk);
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    initial begin
        rst_n = 1'b0;

        // Reset state held across several clock edges.
        repeat (3) @(posedge clk);
        @(negedge clk);
        check_a("reset held", 1'b0, S0, S1);
        check("B reset LED0", {7'd0, led_b}, 8'd0);
        check("B reset HEX4", b_hex4, S1);
        check("B reset HEX0", b_hex0, BLANK);

        // Counting sequence from release, one edge per vector.
        table_a[0] = '{0, 1'b0, S0, S1};
        table_a[1] = '{1, 1'b0, S0, S1};
        table_a[2] = '{1, 1'b1, S0, S1};
        table_a[3] = '{1, 1'b1, S0, S1};
        table_a[4] = '{1, 1'b0, S0, S2};
        table_a[5] = '{1, 1'b0, S0, S2};
        table_a[6] = '{1, 1'b1, S0, S2};
        table_a[7] = '{1, 1'b1, S0, S2};
        table_a[8] = '{1, 1'b0, S0, S3};
        rst_n = 1'b1;
        for (int i = 0; i < 9; i++) begin
            if (table_a[i].clocks > 0) run(table_a[i].clocks);
            check_a($sformatf("seq[%0d]", i), table_a[i].led, table_a[i].hex5, table_a[i].hex4);
        end

        // Reset asserted mid-period with no clock edge: immediate effect.
        @(posedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        check_a("async reset", 1'b0, S0, S1);
        @(negedge clk);
        rst_n = 1'b1;

        // Tens carry: 8 ticks -> 09, one more -> 10.
        do_reset();
        run(32);
        check_a("day 09", 1'b0, S0, S9);
        run(4);
        check_a("day 10", 1'b0, S1, S0);

        // Wrap: 98 ticks -> 99, one more -> 01 (never 00).
        do_reset();
        run(392);
        check_a("day 99", 1'b0, S9, S9);
        run(2);
        check_a("day 99 mid", 1'b1, S9, S9);
        run(2);
        check_a("wrap 01", 1'b0, S0, S1);

        // Reset mid-count at day 37 for half a clock, then resume from 01.
        do_reset();
        run(144);
        check_a("day 37", 1'b0, S3, S7);
        run(2);
        rst_n = 1'b0;
        #1;
        check_a("reset at 37", 1'b0, S0, S1);
        #3;
        rst_n = 1'b1;
        run(3);
        check_a("restart pre3", 1'b1, S0, S1);
        run(1);
        check_a("restart 02", 1'b0, S0, S2);

        // DIV=10: LED0 low for 5 counts, high for 5, one advance per period.
        do_reset();
        begin
            int highs = 0;
            for (int k = 1; k <= 10; k++) begin
                run(1);
                check($sformatf("B LED0 edge %0d", k), {7'd0, led_b},
                      {7'd0, logic'((k % 10) >= 5)});
                if (led_b) highs++;
                if (k == 9) check("B HEX4 before tick", b_hex4, S1);
            end
            check("B LED0 high count", 8'(highs), 8'd5);
            check("B HEX4 after tick", b_hex4, S2);
            check("B HEX5 after tick", b_hex5, S0);
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/day_counter.md
Name: day_counter

Overview:
Free-running day counter for the DE10-Lite board, clocked from the 10 MHz ADC_CLK_10 oscillator. A prescaler divides the clock to a "day tick". A two-digit BCD counter advances 1→99 and wraps to 1 on each tick. The count is shown on HEX5 (tens) and HEX4 (ones); LED0 blinks at the day rate.

Parameters:
DIV, 10_000_000, ADC_CLK_10 cycles per day tick (default = 1 s); must be an even number ≥ 2
CNT_W, 24, prescaler width; must satisfy 2^CNT_W ≥ DIV

Ports:
ADC_CLK_10  input  1  system clock, 10 MHz, rising-edge
reset       input  1  asynchronous, active-low reset (0 = reset)
LED0        output 1  day-rate square wave, 50% duty
HEX0        output 8  7-seg, always blank
HEX1        output 8  7-seg, always blank
HEX2        output 8  7-seg, always blank
HEX3        output 8  7-seg, always blank
HEX4        output 8  7-seg, ones digit of day count
HEX5        output 8  7-seg, tens digit of day count

Behaviour:
- One clock domain, ADC_CLK_10. All state is registered and resets asynchronously while reset=0.
- Reset values:
  - prescaler = 0
  - tens = 0, ones = 1, so the display shows "01"
  - LED0 = 0
  - HEX5 = 0xC0 ('0'), HEX4 = 0xF9 ('1'), HEX0–HEX3 = 0xFF
- Prescaler:
  - Counts 0..DIV-1, incrementing by 1 per clock.
  - At DIV-1, the next value is 0 and a one-cycle internal tick is asserted in that same cycle.
- Day counter:
  - Two BCD digits (tens 0..9, ones 0..9). On each tick:
    - if value = 99 → 01
    - else if ones = 9 → ones = 0, tens = tens + 1
    - else ones = ones + 1
  - The value 00 is never reached after reset. The counter only changes on a tick.
- LED0 is registered: 1 when the prescaler is ≥ DIV/2, otherwise 0. It is 0 for the first half of each day period and 1 for the second half, and falls on the clock edge where the day count advances.
- 7-seg encoding:
  - Active-low; bit0=a … bit6=g, bit7=DP.
  - DP is always off (bit7 = 1).
  - Codes: 0=C0, 1=F9, 2=A4, 3=B0, 4=99, 5=92, 6=82, 7=F8, 8=80, 9=90.
  - A non-BCD digit value never occurs; the decoder default is blank (FF).
- HEX4/HEX5 are a combinational decode of the registered digits. They update in the same cycle the digits change; no extra latency.
- Leading zero is displayed (day 5 shows "05").
- HEX0–HEX3 are constant 0xFF.
- Reset asserted mid-period:
  - All outputs return to their reset values immediately, with no clock required.
  - On release, counting restarts from prescaler 0 and day 01. A partial period is not retained.
- Reset release is assumed synchronous to the board's reset synchronizer; the block itself adds no synchronizer.

Test Plan:
1. DIV=4. Hold reset=0, toggle the clock → HEX5=C0, HEX4=F9, LED0=0, HEX0–3=FF. Assert reset mid-clock with no edge → outputs go to these values at once.
2. DIV=4. Release reset, run 4 clocks:
   - LED0 is 0,0,1,1 across prescaler 0..3.
   - After the 4th edge: HEX4=A4 ('2'), HEX5=C0, LED0=0.
3. DIV=4. Run 8 ticks from reset → display "09" (HEX5=C0, HEX4=90). Next tick → "10" (HEX5=F9, HEX4=C0).
4. DIV=4. Run 98 ticks from reset → "99" (HEX5=90, HEX4=90). Next tick → "01" (HEX5=C0, HEX4=F9), never 00.
5. DIV=4. Mid-count at day 37, pull reset low for half a clock → immediately "01" and LED0=0. After release, 4 clocks → "02".
6. Default DIV. Run 10,000,000 clocks → day advances exactly once and LED0 makes one full 0→1→0 cycle.
